// File: rtl/round_controller_pkg.sv
// Shared definitions for the morse round game: FSM states, round winner
// codes, morse symbol encodings and a saturating score increment.
// Imported by the round controller and the entry/guess datapath blocks.
package round_controller_pkg;

   typedef enum logic [2:0] {
      IDLE      = 3'd0,
      P1_ENTRY  = 3'd1,
      P2_GUESS  = 3'd2,
      ROUND_END = 3'd3,
      GAME_OVER = 3'd4
   } state_t;

   localparam logic [1:0] WIN_NONE = 2'b00;
   localparam logic [1:0] WIN_P1   = 2'b01;
   localparam logic [1:0] WIN_P2   = 2'b10;

   // Morse symbols shared by the player-1 entry and player-2 guess blocks.
   localparam logic [1:0] SYM_NONE = 2'b00;
   localparam logic [1:0] SYM_DOT  = 2'b01;
   localparam logic [1:0] SYM_LINE = 2'b11;

   // Scores are 3 bits wide and stick at 7.
   function automatic logic [2:0] sat_inc(input logic [2:0] v);
      return (v == 3'd7) ? v : v + 3'd1;
   endfunction

endpackage

// File: rtl/round_controller_if.sv
// Game-control bus between the round controller and its environment.
// Inputs: start, p1_done, p1_value, p2_submit, p2_complete.
// Outputs: enables, p2_clear_n, code, countdown, attempts, scores, round state.
interface round_controller_if;

   logic       start;
   logic       p1_done;
   logic [9:0] p1_value;
   logic       p2_submit;
   logic       p2_complete;

   logic       p1_enable;
   logic       p2_enable;
   logic       p2_clear_n;
   logic [9:0] code;
   logic [5:0] time_left;
   logic [2:0] attempts_left;
   logic [2:0] p1_score;
   logic [2:0] p2_score;
   logic [2:0] round_num;
   logic [1:0] round_winner;
   logic       game_over;

   // Environment side: players, entry and guess datapaths.
   modport master (
      output start, p1_done, p1_value, p2_submit, p2_complete,
      input  p1_enable, p2_enable, p2_clear_n, code, time_left, attempts_left,
             p1_score, p2_score, round_num, round_winner, game_over
   );

   // Controller side.
   modport slave (
      input  start, p1_done, p1_value, p2_submit, p2_complete,
      output p1_enable, p2_enable, p2_clear_n, code, time_left, attempts_left,
             p1_score, p2_score, round_num, round_winner, game_over
   );

endinterface

// File: rtl/round_controller_sec_prescaler.sv
// One-second tick generator: counts 0..CLK_PER_SEC-1, tick high on the last count.
// Ports: clock, resetn (async active-low), restart (forces count to 0 next edge), tick.
// First tick appears CLK_PER_SEC cycles after the edge that applied restart.
module sec_prescaler #(
   parameter int CLK_PER_SEC = 50_000_000
) (
   input  logic clock,
   input  logic resetn,
   input  logic restart,
   output logic tick
);

   localparam int            CW   = (CLK_PER_SEC > 1) ? $clog2(CLK_PER_SEC) : 1;
   localparam logic [CW-1:0] LAST = CW'(CLK_PER_SEC - 1);

   logic [CW-1:0] cnt;

   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         cnt <= '0;
      end else if (restart || (cnt == LAST)) begin
         cnt <= '0;
      end else begin
         cnt <= cnt + CW'(1);
      end
   end

   assign tick = (cnt == LAST);

endmodule

// File: rtl/round_controller.sv
// Morse round sequencer: gates player-1 entry, latches the code, runs the
// player-2 countdown/attempt limit, awards rounds and keeps score.
// Ports: clock, resetn (async active-low), bus (round_controller_if.slave).
module round_controller
   import round_controller_pkg::*;
#(
   parameter int CLK_PER_SEC   = 50_000_000,
   parameter int ROUND_SECONDS = 30,
   parameter int MAX_ATTEMPTS  = 3,
   parameter int NUM_ROUNDS    = 4,
   parameter int HOLD_SECONDS  = 2
) (
   input  logic               clock,
   input  logic               resetn,
   round_controller_if.slave  bus
);

   state_t     state;
   logic [9:0] code_q;
   logic [5:0] time_q;
   logic [2:0] attempts_q;
   logic [2:0] p1_score_q;
   logic [2:0] p2_score_q;
   logic [2:0] round_q;
   logic [1:0] winner_q;
   logic       clear_n_q;
   logic [5:0] hold_q;

   logic       tick;
   logic       restart;
   logic       code_ok;
   logic       guess_over;
   logic       hold_done;
   logic [2:0] next_round;

   assign code_ok    = bus.p1_done && (bus.p1_value != 10'd0);
   // A submit always takes precedence over a tick in the same cycle, so the
   // final tick only ends the round when no submit is present.
   assign guess_over = (state == P2_GUESS) &&
                       (bus.p2_submit ? (bus.p2_complete || (attempts_q == 3'd1))
                                      : (tick && (time_q == 6'd1)));
   assign hold_done  = tick && (hold_q == 6'(HOLD_SECONDS - 1));
   assign next_round = round_q + 3'd1;

   // Hold the prescaler at zero outside the timed states and on the edge that
   // leaves P2_GUESS, so each timed state starts a fresh second.
   assign restart = !((state == P2_GUESS) || (state == ROUND_END)) || guess_over;

   sec_prescaler #(.CLK_PER_SEC(CLK_PER_SEC)) u_prescaler (
      .clock   (clock),
      .resetn  (resetn),
      .restart (restart),
      .tick    (tick)
   );

   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         state      <= IDLE;
         code_q     <= '0;
         time_q     <= '0;
         attempts_q <= '0;
         p1_score_q <= '0;
         p2_score_q <= '0;
         round_q    <= '0;
         winner_q   <= WIN_NONE;
         clear_n_q  <= 1'b1;
         hold_q     <= '0;
      end else begin
         clear_n_q <= 1'b1;
         case (state)
            IDLE, GAME_OVER: begin
               if (bus.start) begin
                  state      <= P1_ENTRY;
                  p1_score_q <= '0;
                  p2_score_q <= '0;
                  round_q    <= '0;
                  winner_q   <= WIN_NONE;
               end
            end
            P1_ENTRY: begin
               if (code_ok) begin
                  state      <= P2_GUESS;
                  code_q     <= bus.p1_value;
                  time_q     <= 6'(ROUND_SECONDS);
                  attempts_q <= 3'(MAX_ATTEMPTS);
                  winner_q   <= WIN_NONE;
                  clear_n_q  <= 1'b0;
               end
            end
            P2_GUESS: begin
               if (bus.p2_submit && bus.p2_complete) begin
                  p2_score_q <= sat_inc(p2_score_q);
                  winner_q   <= WIN_P2;
               end else if (bus.p2_submit) begin
                  attempts_q <= attempts_q - 3'd1;
                  clear_n_q  <= 1'b0;
                  if (attempts_q == 3'd1) begin
                     p1_score_q <= sat_inc(p1_score_q);
                     winner_q   <= WIN_P1;
                  end else if (tick && (time_q != 6'd1)) begin
                     time_q <= time_q - 6'd1;
                  end
               end else if (tick) begin
                  time_q <= time_q - 6'd1;
                  if (time_q == 6'd1) begin
                     p1_score_q <= sat_inc(p1_score_q);
                     winner_q   <= WIN_P1;
                  end
               end
               if (guess_over) begin
                  state  <= ROUND_END;
                  hold_q <= '0;
               end
            end
            ROUND_END: begin
               if (hold_done) begin
                  round_q <= next_round;
                  state   <= (next_round == 3'(NUM_ROUNDS)) ? GAME_OVER : P1_ENTRY;
               end else if (tick) begin
                  hold_q <= hold_q + 6'd1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign bus.p1_enable     = (state == P1_ENTRY);
   assign bus.p2_enable     = (state == P2_GUESS);
   assign bus.game_over     = (state == GAME_OVER);
   assign bus.p2_clear_n    = clear_n_q;
   assign bus.code          = code_q;
   assign bus.time_left     = time_q;
   assign bus.attempts_left = attempts_q;
   assign bus.p1_score      = p1_score_q;
   assign bus.p2_score      = p2_score_q;
   assign bus.round_num     = round_q;
   assign bus.round_winner  = winner_q;

endmodule

// File: tb/tb_round_controller.sv
// Directed bench for round_controller with a 4-cycle second, 3 s rounds,
// 2 attempts, 2 rounds per game and a 1 s result hold.
// Inputs are driven 1 time unit after the rising edge; outputs sampled there too.
module tb_round_controller;

   logic clock  = 1'b0;
   logic resetn = 1'b0;
   int   n_vec  = 0;
   int   n_err  = 0;

   round_controller_if bus ();

   round_controller #(
      .CLK_PER_SEC   (4),
      .ROUND_SECONDS (3),
      .MAX_ATTEMPTS  (2),
      .NUM_ROUNDS    (2),
      .HOLD_SECONDS  (1)
   ) dut (
      .clock  (clock),
      .resetn (resetn),
      .bus    (bus)
   );

   always #5 clock = ~clock;

   initial begin
      #50000;
      $display("FAIL watchdog: run did not reach the summary line");
      $fatal(1);
   end

   task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic step(input int n = 1);
      repeat (n) begin
         @(posedge clock);
         #1;
      end
   endtask

   task automatic pulse_start();
      bus.start = 1'b1;
      step();
      bus.start = 1'b0;
   endtask

   task automatic enter_code(input logic [9:0] v);
      bus.p1_value = v;
      bus.p1_done  = 1'b1;
      step();
      bus.p1_done  = 1'b0;
   endtask

   task automatic submit(input logic ok);
      bus.p2_submit   = 1'b1;
      bus.p2_complete = ok;
      step();
      bus.p2_submit   = 1'b0;
      bus.p2_complete = 1'b0;
   endtask

   initial begin
      bus.start       = 1'b0;
      bus.p1_done     = 1'b0;
      bus.p1_value    = 10'd0;
      bus.p2_submit   = 1'b0;
      bus.p2_complete = 1'b0;

      // Reset values
      step(2);
      check("rst_clear_n", 16'(bus.p2_clear_n), 16'd1);
      check("rst_flags", 16'({bus.p1_enable, bus.p2_enable, bus.game_over, bus.round_winner}), 16'd0);
      check("rst_counts", 16'({bus.round_num, bus.p1_score, bus.p2_score, bus.attempts_left}), 16'd0);
      check("rst_code", 16'(bus.code), 16'd0);
      check("rst_time", 16'(bus.time_left), 16'd0);
      resetn = 1'b1;
      step();

      // IDLE ignores p1_done
      enter_code(10'h3FF);
      check("idle_enables", 16'({bus.p1_enable, bus.p2_enable}), 16'd0);
      check("idle_code", 16'(bus.code), 16'd0);

      // Game 1
      pulse_start();
      check("start_p1_en", 16'(bus.p1_enable), 16'd1);
      enter_code(10'd0);
      check("zero_code_stay", 16'({bus.p1_enable, bus.p2_enable, bus.p2_clear_n}), 16'b101);

      // Round 1: accepted entry then player 2 wins in cycle 5
      enter_code(10'b0101110000);
      check("acc_code", 16'(bus.code), 16'h170);
      check("acc_time", 16'(bus.time_left), 16'd3);
      check("acc_attempts", 16'(bus.attempts_left), 16'd2);
      check("acc_clear_lo", 16'(bus.p2_clear_n), 16'd0);
      check("acc_enables", 16'({bus.p1_enable, bus.p2_enable}), 16'b01);
      step();
      check("acc_clear_hi", 16'(bus.p2_clear_n), 16'd1);
      step(3);
      check("r1_tick1", 16'(bus.time_left), 16'd2);
      step();
      submit(1'b1);
      check("r1_p2_score", 16'(bus.p2_score), 16'd1);
      check("r1_p1_score", 16'(bus.p1_score), 16'd0);
      check("r1_winner", 16'(bus.round_winner), 16'b10);
      check("r1_p2_en_off", 16'(bus.p2_enable), 16'd0);
      step(3);
      check("r1_hold", 16'({bus.p1_enable, bus.round_num}), 16'd0);
      step();
      check("r1_reentry", 16'({bus.p1_enable, bus.round_num}), 16'b1001);
      check("r1_winner_held", 16'(bus.round_winner), 16'b10);

      // Round 2: attempts exhausted
      enter_code(10'b1101010111);
      check("r2_code", 16'(bus.code), 16'h357);
      check("r2_winner_clr", 16'(bus.round_winner), 16'd0);
      step();
      submit(1'b0);
      check("r2_att1", 16'(bus.attempts_left), 16'd1);
      check("r2_clr1", 16'({bus.p2_clear_n, bus.p2_enable}), 16'b01);
      step();
      check("r2_clr1_hi", 16'(bus.p2_clear_n), 16'd1);
      step();
      check("r2_time", 16'(bus.time_left), 16'd2);
      submit(1'b0);
      check("r2_att0", 16'(bus.attempts_left), 16'd0);
      check("r2_clr2", 16'(bus.p2_clear_n), 16'd0);
      check("r2_p1_score", 16'(bus.p1_score), 16'd1);
      check("r2_winner", 16'(bus.round_winner), 16'b01);
      check("r2_p2_en_off", 16'(bus.p2_enable), 16'd0);
      step(3);
      check("r2_hold", 16'(bus.game_over), 16'd0);
      step();
      check("g1_over", 16'(bus.game_over), 16'd1);
      check("g1_rounds", 16'(bus.round_num), 16'd2);
      check("g1_scores", 16'({bus.p1_score, bus.p2_score}), 16'({3'd1, 3'd1}));

      // GAME_OVER ignores entry and submit
      enter_code(10'h155);
      submit(1'b1);
      check("go_held", 16'({bus.game_over, bus.p1_enable, bus.p2_enable}), 16'b100);
      check("go_code_held", 16'(bus.code), 16'h357);
      check("go_scores_held", 16'({bus.p1_score, bus.p2_score}), 16'({3'd1, 3'd1}));

      // Game 2: restart clears scores
      pulse_start();
      check("g2_start", 16'({bus.p1_enable, bus.game_over}), 16'b10);
      check("g2_cleared", 16'({bus.p1_score, bus.p2_score, bus.round_num, bus.round_winner}), 16'd0);

      // Round 1: timeout at 12 cycles
      enter_code(10'h2AB);
      step(4);
      check("to_t2", 16'(bus.time_left), 16'd2);
      step(4);
      check("to_t1", 16'(bus.time_left), 16'd1);
      step(3);
      check("to_c11", 16'(bus.p2_enable), 16'd1);
      step();
      check("to_c12_end", 16'(bus.p2_enable), 16'd0);
      check("to_t0", 16'(bus.time_left), 16'd0);
      check("to_p1_score", 16'(bus.p1_score), 16'd1);
      check("to_winner", 16'(bus.round_winner), 16'b01);
      step(4);
      check("to_reentry", 16'({bus.p1_enable, bus.round_num}), 16'b1001);

      // Round 2: correct submit coincides with the final tick
      enter_code(10'h0C3);
      step(11);
      check("fin_t1", 16'({bus.p2_enable, bus.time_left}), 16'({1'b1, 6'd1}));
      submit(1'b1);
      check("fin_p2_score", 16'(bus.p2_score), 16'd1);
      check("fin_p1_score", 16'(bus.p1_score), 16'd1);
      check("fin_winner", 16'(bus.round_winner), 16'b10);
      check("fin_tick_drop", 16'(bus.time_left), 16'd1);
      step(4);
      check("g2_over", 16'({bus.game_over, bus.round_num}), 16'b1010);

      // Game 3: asynchronous reset in P2_GUESS while clear pulse is low
      pulse_start();
      enter_code(10'h001);
      check("g3_clear_lo", 16'(bus.p2_clear_n), 16'd0);
      #2;
      resetn = 1'b0;
      #1;
      check("ar_clear_n", 16'(bus.p2_clear_n), 16'd1);
      check("ar_flags", 16'({bus.p1_enable, bus.p2_enable, bus.game_over, bus.round_winner}), 16'd0);
      check("ar_counts", 16'({bus.round_num, bus.p1_score, bus.p2_score, bus.attempts_left}), 16'd0);
      check("ar_code_time", 16'({bus.code, bus.time_left}), 16'd0);
      step(2);
      resetn = 1'b1;
      step();
      check("ar_idle", 16'({bus.p1_enable, bus.p2_enable}), 16'd0);
      pulse_start();
      check("ar_restart", 16'(bus.p1_enable), 16'd1);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/round_controller.md
# round_controller

Game sequencer for the two-player morse round. It gates player 1's code entry, latches the accepted code and hands it to the player-2 guess datapath. It also enforces a per-round countdown and attempt limit, awards the round and keeps score over a fixed number of rounds. It sits above the player-1 entry block and the player-2 compare block, and drives their enables and player 2's reset.

## Interface
Parameters:
- CLK_PER_SEC, 50_000_000: clock cycles per countdown second.
- ROUND_SECONDS, 30: countdown load value, 1..63.
- MAX_ATTEMPTS, 3: wrong submissions allowed per round, 1..7.
- NUM_ROUNDS, 4: rounds per game, 1..7.
- HOLD_SECONDS, 2: result display time after a round, 1..63.

Ports:
- clock  in  1  system clock, all logic on rising edge.
- resetn  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle pulse: begin a game, or restart from GAME_OVER.
- p1_done  in  1  one-cycle pulse: player 1 finished entry.
- p1_value  in  10  player 1's morse code, five 2-bit symbols, MSB first.
- p2_submit  in  1  one-cycle pulse: player 2 submits a guess.
- p2_complete  in  1  level from the guess datapath: guess equals code.
- p1_enable  out  1  player-1 entry allowed.
- p2_enable  out  1  player-2 guessing allowed.
- p2_clear_n  out  1  active-low one-cycle pulse clearing player 2's partial guess.
- code  out  10  latched round code fed to the guess datapath.
- time_left  out  6  seconds remaining in the round.
- attempts_left  out  3  wrong submissions still allowed.
- p1_score, p2_score  out  3 each  rounds won.
- round_num  out  3  rounds completed.
- round_winner  out  2  00 none, 01 player 1, 10 player 2.
- game_over  out  1  high in GAME_OVER.

## Operation
Reset values: state IDLE, all outputs 0, except p2_clear_n=1.

IDLE
- All enables are 0.
- start moves to P1_ENTRY and clears the scores, round_num and round_winner.

P1_ENTRY
- p1_enable=1.
- p1_done with p1_value≠0 performs these actions and moves to P2_GUESS:
  - latch code ← p1_value;
  - time_left ← ROUND_SECONDS;
  - attempts_left ← MAX_ATTEMPTS;
  - round_winner ← 00;
  - pulse p2_clear_n low.
- p1_done with p1_value=0 is ignored; the state stays P1_ENTRY.

P2_GUESS
- p2_enable=1.
- Each second tick decrements time_left.
- p2_submit with p2_complete=1: p2_score+1, round_winner=10, move to ROUND_END.
- p2_submit with p2_complete=0: attempts_left−1 and pulse p2_clear_n. If attempts_left was 1, p1_score+1, round_winner=01, move to ROUND_END.
- time_left reaching 0 (tick while time_left=1): p1_score+1, round_winner=01, move to ROUND_END.
- If a submit and the final tick occur in the same cycle, the submit is evaluated and the tick is discarded. A correct guess in that cycle therefore wins for player 2.

ROUND_END
- Enables are 0. round_winner and the scores are held.
- After HOLD_SECONDS ticks, round_num+1.
- If round_num then equals NUM_ROUNDS, move to GAME_OVER; otherwise move to P1_ENTRY.

GAME_OVER
- game_over=1 and all values are held.
- start behaves as in IDLE (new game).

start is ignored in every state other than IDLE and GAME_OVER. Inputs not named for the current state are ignored.

## Timing
- Moore outputs are decoded from the registered state. Enables change on the clock edge that changes state.
- p2_clear_n is registered. It is low for exactly the cycle after the accepting p1_done or the wrong p2_submit.
- The second prescaler counts 0..CLK_PER_SEC−1 and restarts to 0 on entry to P2_GUESS and to ROUND_END.
  - The first tick arrives CLK_PER_SEC cycles after entry.
  - A full countdown takes ROUND_SECONDS×CLK_PER_SEC cycles from entry.
- Scores and counters update on the same edge as the transition they cause.
- Score counters saturate at 7.
- An asynchronous resetn at any point returns everything to the reset values within the same instant, without a clock.

## Structure
- The shared package holds:
  - state encodings IDLE/P1_ENTRY/P2_GUESS/ROUND_END/GAME_OVER;
  - the round_winner codes;
  - the morse symbol constants NONE=00, DOT=01, LINE=11 used by the entry and guess blocks.
- One sub-module, sec_prescaler (inputs clock, resetn, restart; output one-cycle tick), parameterised by CLK_PER_SEC.

## Test plan
Run with CLK_PER_SEC=4, ROUND_SECONDS=3, MAX_ATTEMPTS=2, NUM_ROUNDS=2, HOLD_SECONDS=1.
- Accepted entry: start, then p1_done with p1_value=10'b0101110000 → code=0x170, time_left=3, attempts_left=2, one-cycle low on p2_clear_n, p2_enable=1.
- Player 2 wins: submit with p2_complete=1 at cycle 5 of the round → p2_score=1, round_winner=10. P1_ENTRY is re-entered 4 cycles later with round_num=1.
- Attempts exhausted: two submits with p2_complete=0 → attempts_left 2→1→0, two p2_clear_n pulses, p1_score=1, round_winner=01.
- Timeout: no submits → time_left 3,2,1 then ROUND_END exactly 12 cycles after entry, p1_score+1. A correct submit in cycle 12 instead gives p2_score+1.
- Zero-code entry and game end: p1_done with p1_value=0 → remains in P1_ENTRY. After two rounds → game_over=1. start → scores=0, P1_ENTRY.
- Mid-game reset: assert resetn low during P2_GUESS → all outputs 0 and p2_clear_n=1 immediately. IDLE after release.
